// File: rtl/pm_reservation_station_pkg.sv
// Shared constants for the plus/minus ALU dispatch path.
// Contents:
//   ALU_ADD / ALU_SUB          - ALU add/sub op encodings
//   TAG_NONE                   - reserved producer tag: operand value present
//   DEF_TAG_W / DEF_DATA_W     - default tag and operand widths
//   disp_state_e               - dispatch FSM state encodings
package pm_reservation_station_pkg;

  localparam int DEF_TAG_W  = 4;
  localparam int DEF_DATA_W = 32;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  localparam int TAG_NONE = 0;

  typedef enum logic {
    DISP_IDLE  = 1'b0,
    DISP_OFFER = 1'b1
  } disp_state_e;

endpackage

// File: rtl/pm_reservation_station_rs_age_select.sv
// Oldest-ready picker for the reservation station.
// Ports:
//   ready     in  N      per-slot ready flags
//   age       in  NxN    age[i][j]=1 means slot i is older than slot j
//   grant     out N      one-hot: the ready slot with no older ready slot
//   any_ready out 1      at least one slot is ready
module rs_age_select #(
  parameter int N = 3
) (
  input  logic [N-1:0]        ready,
  input  logic [N-1:0][N-1:0] age,
  output logic [N-1:0]        grant,
  output logic                any_ready
);

  logic [N-1:0] blocked;

  always_comb begin
    blocked = '0;
    grant   = '0;
    for (int i = 0; i < N; i++) begin
      // Slot i loses if any other ready slot is older than it.
      for (int j = 0; j < N; j++) begin
        if (j != i && ready[j] && age[j][i]) blocked[i] = 1'b1;
      end
      grant[i] = ready[i] && !blocked[i];
    end
  end

  assign any_ready = |ready;

endmodule

// File: rtl/pm_reservation_station.sv
// Add/subtract reservation station; initiator of the ALU dispatch interface.
// Ports:
//   clk, nRST (async active-low), flush (sync clear)
//   issue_*  : issue_valid/issue_ready handshake, op, Vj/Qj, Vk/Qk, issue_tag
//   cdb_*    : common data bus snoop (valid, tag, data)
//   alu_*    : registered dispatch offer (en, op, data1, data2, tag), alu_ack
// Handshakes: an issue transfers on a cycle with issue_valid && issue_ready.
// An offer is presented with alu_en=1 and held unchanged until the cycle in
// which alu_ack=1; that edge retires the slot and may load the next offer.
module pm_reservation_station
  import pm_reservation_station_pkg::*;
#(
  parameter int ENTRIES = 3,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RS_BASE = 1
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic              issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qk,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              alu_en,
  output logic              alu_op,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [TAG_W-1:0]  alu_tag,
  input  logic              alu_ack
);

  localparam logic [TAG_W-1:0] TAG_Z = TAG_W'(TAG_NONE);

  logic [ENTRIES-1:0]              busy_q, busy_d, disp_q, disp_d, op_q, op_d;
  logic [ENTRIES-1:0][DATA_W-1:0]  vj_q, vj_d, vk_q, vk_d;
  logic [ENTRIES-1:0][TAG_W-1:0]   qj_q, qj_d, qk_q, qk_d;
  logic [ENTRIES-1:0][ENTRIES-1:0] age_q, age_d;
  disp_state_e                     state_q, state_d;
  logic                            alu_en_q, alu_en_d, alu_op_q, alu_op_d;
  logic [DATA_W-1:0]               alu_data1_q, alu_data1_d, alu_data2_q, alu_data2_d;
  logic [TAG_W-1:0]                alu_tag_q, alu_tag_d;

  logic [ENTRIES-1:0] ready, grant, free_sel;
  logic               any_ready, issue_fire;
  logic               sel_op;
  logic [DATA_W-1:0]  sel_vj, sel_vk;
  logic [TAG_W-1:0]   sel_tag;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ready[i] = busy_q[i] && !disp_q[i] && qj_q[i] == TAG_Z && qk_q[i] == TAG_Z;
    end
  end

  rs_age_select #(.N(ENTRIES)) u_age_select (
    .ready     (ready),
    .age       (age_q),
    .grant     (grant),
    .any_ready (any_ready)
  );

  // Lowest clear bit of busy_q: adding one ripples through the low run of
  // ones and lands on the first zero.
  assign free_sel    = ~busy_q & (busy_q + ENTRIES'(1));
  assign issue_ready = |free_sel;
  assign issue_fire  = issue_valid && issue_ready;

  always_comb begin
    issue_tag = '0;
    sel_op    = 1'b0;
    sel_vj    = '0;
    sel_vk    = '0;
    sel_tag   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (free_sel[i]) issue_tag = TAG_W'(RS_BASE + i);
      if (grant[i]) begin
        sel_op  = op_q[i];
        sel_vj  = vj_q[i];
        sel_vk  = vk_q[i];
        sel_tag = TAG_W'(RS_BASE + i);
      end
    end
  end

  always_comb begin
    busy_d      = busy_q;
    disp_d      = disp_q;
    op_d        = op_q;
    vj_d        = vj_q;
    qj_d        = qj_q;
    vk_d        = vk_q;
    qk_d        = qk_q;
    age_d       = age_q;
    state_d     = state_q;
    alu_en_d    = alu_en_q;
    alu_op_d    = alu_op_q;
    alu_data1_d = alu_data1_q;
    alu_data2_d = alu_data2_q;
    alu_tag_d   = alu_tag_q;

    // CDB snoop on waiting operands.
    for (int i = 0; i < ENTRIES; i++) begin
      if (busy_q[i] && cdb_valid) begin
        if (qj_q[i] != TAG_Z && qj_q[i] == cdb_tag) begin
          vj_d[i] = cdb_data;
          qj_d[i] = TAG_Z;
        end
        if (qk_q[i] != TAG_Z && qk_q[i] == cdb_tag) begin
          vk_d[i] = cdb_data;
          qk_d[i] = TAG_Z;
        end
      end
    end

    // Dispatch. Only one slot is ever dispatched, so disp_q marks the slot
    // currently on offer and is what an ack retires.
    case (state_q)
      DISP_IDLE: begin
        if (any_ready) begin
          alu_en_d    = 1'b1;
          alu_op_d    = sel_op;
          alu_data1_d = sel_vj;
          alu_data2_d = sel_vk;
          alu_tag_d   = sel_tag;
          disp_d      = disp_q | grant;
          state_d     = DISP_OFFER;
        end
      end
      DISP_OFFER: begin
        if (alu_ack) begin
          busy_d = busy_q & ~disp_q;
          disp_d = '0;
          if (any_ready) begin
            alu_op_d    = sel_op;
            alu_data1_d = sel_vj;
            alu_data2_d = sel_vk;
            alu_tag_d   = sel_tag;
            disp_d      = grant;
          end else begin
            alu_en_d = 1'b0;
            state_d  = DISP_IDLE;
          end
        end
      end
      default: state_d = DISP_IDLE;
    endcase

    // Issue into the lowest free slot; it becomes the youngest entry.
    if (issue_fire) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (free_sel[i]) begin
          busy_d[i] = 1'b1;
          disp_d[i] = 1'b0;
          op_d[i]   = issue_op;
          if (cdb_valid && issue_qj != TAG_Z && issue_qj == cdb_tag) begin
            vj_d[i] = cdb_data;
            qj_d[i] = TAG_Z;
          end else begin
            vj_d[i] = issue_vj;
            qj_d[i] = issue_qj;
          end
          if (cdb_valid && issue_qk != TAG_Z && issue_qk == cdb_tag) begin
            vk_d[i] = cdb_data;
            qk_d[i] = TAG_Z;
          end else begin
            vk_d[i] = issue_vk;
            qk_d[i] = issue_qk;
          end
          age_d[i] = '0;
          for (int j = 0; j < ENTRIES; j++) begin
            if (busy_q[j]) age_d[j][i] = 1'b1;
          end
        end
      end
    end

    if (flush) begin
      busy_d   = '0;
      disp_d   = '0;
      alu_en_d = 1'b0;
      state_d  = DISP_IDLE;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      busy_q      <= '0;
      disp_q      <= '0;
      op_q        <= '0;
      vj_q        <= '0;
      qj_q        <= '0;
      vk_q        <= '0;
      qk_q        <= '0;
      age_q       <= '0;
      state_q     <= DISP_IDLE;
      alu_en_q    <= 1'b0;
      alu_op_q    <= ALU_ADD;
      alu_data1_q <= '0;
      alu_data2_q <= '0;
      alu_tag_q   <= '0;
    end else begin
      busy_q      <= busy_d;
      disp_q      <= disp_d;
      op_q        <= op_d;
      vj_q        <= vj_d;
      qj_q        <= qj_d;
      vk_q        <= vk_d;
      qk_q        <= qk_d;
      age_q       <= age_d;
      state_q     <= state_d;
      alu_en_q    <= alu_en_d;
      alu_op_q    <= alu_op_d;
      alu_data1_q <= alu_data1_d;
      alu_data2_q <= alu_data2_d;
      alu_tag_q   <= alu_tag_d;
    end
  end

  assign alu_en    = alu_en_q;
  assign alu_op    = alu_op_q;
  assign alu_data1 = alu_data1_q;
  assign alu_data2 = alu_data2_q;
  assign alu_tag   = alu_tag_q;

endmodule

// File: tb/tb_pm_reservation_station.sv
// Directed bench for pm_reservation_station (ENTRIES=3, RS_BASE=1).
// Expected ALU offers are queued in exp_q as {op, tag, data1, data2}.
module tb_pm_reservation_station;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int CW     = 1 + TAG_W + 2 * DATA_W;

  logic              clk = 1'b0;
  logic              nRST;
  logic              flush;
  logic              issue_valid;
  logic              issue_ready;
  logic              issue_op;
  logic [DATA_W-1:0] issue_vj;
  logic [TAG_W-1:0]  issue_qj;
  logic [DATA_W-1:0] issue_vk;
  logic [TAG_W-1:0]  issue_qk;
  logic [TAG_W-1:0]  issue_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              alu_en;
  logic              alu_op;
  logic [DATA_W-1:0] alu_data1;
  logic [DATA_W-1:0] alu_data2;
  logic [TAG_W-1:0]  alu_tag;
  logic              alu_ack;

  logic [CW-1:0] alu_word;
  logic [CW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  assign alu_word = {alu_op, alu_tag, alu_data1, alu_data2};

  pm_reservation_station #(
    .ENTRIES (3),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W),
    .RS_BASE (1)
  ) dut (
    .clk         (clk),
    .nRST        (nRST),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_op    (issue_op),
    .issue_vj    (issue_vj),
    .issue_qj    (issue_qj),
    .issue_vk    (issue_vk),
    .issue_qk    (issue_qk),
    .issue_tag   (issue_tag),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .alu_en      (alu_en),
    .alu_op      (alu_op),
    .alu_data1   (alu_data1),
    .alu_data2   (alu_data2),
    .alu_tag     (alu_tag),
    .alu_ack     (alu_ack)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  // Checking
  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [CW-1:0] mk(input logic op, input logic [TAG_W-1:0] tag,
                                       input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2);
    return {op, tag, d1, d2};
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic op, input logic [DATA_W-1:0] vj, input logic [TAG_W-1:0] qj,
                          input logic [DATA_W-1:0] vk, input logic [TAG_W-1:0] qk);
    issue_op    = op;
    issue_vj    = vj;
    issue_qj    = qj;
    issue_vk    = vk;
    issue_qk    = qk;
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic chk_offer(input string tag);
    logic [CW-1:0] e;
    e = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk({tag, "_en"}, CW'(alu_en), CW'(1'b1));
    chk({tag, "_word"}, alu_word, e);
  endtask

  task automatic ack_offer(input string tag);
    chk_offer(tag);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    alu_ack = 1'b1;
    step();
    alu_ack = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_op = 1'b0;
    issue_vj = '0; issue_qj = '0; issue_vk = '0; issue_qk = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; alu_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", CW'(alu_en), CW'(1'b0));
    chk("rst_word", alu_word, '0);
    chk("rst_ready", CW'(issue_ready), CW'(1'b1));
    chk("rst_issue_tag", CW'(issue_tag), CW'(4'd1));
    nRST = 1'b1;
    step();

    // 1: ready add, hold without ack, then ack
    issue_op = 1'b0; issue_vj = 32'd5; issue_qj = '0; issue_vk = 32'd7; issue_qk = '0;
    issue_valid = 1'b1;
    #1;
    chk("t1_issue_tag", CW'(issue_tag), CW'(4'd1));
    step();
    issue_valid = 1'b0;
    chk("t1_no_en_at_issue", CW'(alu_en), CW'(1'b0));
    exp_q.push_back(mk(1'b0, 4'd1, 32'd5, 32'd7));
    step();
    chk_offer("t1_offer");
    for (int i = 0; i < 3; i++) begin
      step();
      chk_offer("t1_hold");
    end
    ack_offer("t1_ack");
    chk("t1_en_off", CW'(alu_en), CW'(1'b0));
    chk("t1_ready", CW'(issue_ready), CW'(1'b1));

    // 2: sub waiting on tag 9, resolved by CDB
    do_issue(1'b1, 32'd0, 4'd9, 32'd3, 4'd0);
    step();
    chk("t2_wait0", CW'(alu_en), CW'(1'b0));
    step();
    chk("t2_wait1", CW'(alu_en), CW'(1'b0));
    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'd20;
    step();
    cdb_valid = 1'b0;
    chk("t2_capture_edge", CW'(alu_en), CW'(1'b0));
    exp_q.push_back(mk(1'b1, 4'd1, 32'd20, 32'd3));
    step();
    ack_offer("t2_offer");
    chk("t2_en_off", CW'(alu_en), CW'(1'b0));

    // 3: same-cycle CDB bypass on k
    cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 32'hFFFF_FFFF;
    do_issue(1'b0, 32'd10, 4'd0, 32'd0, 4'd6);
    cdb_valid = 1'b0;
    chk("t3_no_en_at_issue", CW'(alu_en), CW'(1'b0));
    exp_q.push_back(mk(1'b0, 4'd1, 32'd10, 32'hFFFF_FFFF));
    step();
    ack_offer("t3_offer");
    chk("t3_en_off", CW'(alu_en), CW'(1'b0));

    // 4: fill all slots, 4th issue ignored, back-to-back dispatch
    exp_q.push_back(mk(1'b0, 4'd1, 32'd1, 32'd2));
    exp_q.push_back(mk(1'b1, 4'd2, 32'd100, 32'd40));
    exp_q.push_back(mk(1'b0, 4'd3, 32'hFFFF_FFFF, 32'd1));
    do_issue(1'b0, 32'd1, 4'd0, 32'd2, 4'd0);
    do_issue(1'b1, 32'd100, 4'd0, 32'd40, 4'd0);
    do_issue(1'b0, 32'hFFFF_FFFF, 4'd0, 32'd1, 4'd0);
    chk("t4_full", CW'(issue_ready), CW'(1'b0));
    do_issue(1'b1, 32'd77, 4'd0, 32'd88, 4'd0);
    chk("t4_still_full", CW'(issue_ready), CW'(1'b0));
    chk_offer("t4_A");
    void'(exp_q.pop_front());
    alu_ack = 1'b1;
    step();
    chk_offer("t4_B");
    void'(exp_q.pop_front());
    step();
    chk_offer("t4_C");
    void'(exp_q.pop_front());
    step();
    alu_ack = 1'b0;
    chk("t4_en_off", CW'(alu_en), CW'(1'b0));
    chk("t4_ready", CW'(issue_ready), CW'(1'b1));
    step();
    step();
    chk("t4_no_ghost", CW'(alu_en), CW'(1'b0));

    // ack in IDLE is ignored
    alu_ack = 1'b1;
    step();
    alu_ack = 1'b0;
    chk("idle_ack_en", CW'(alu_en), CW'(1'b0));
    chk("idle_ack_ready", CW'(issue_ready), CW'(1'b1));

    // 5: younger ready slot goes first, older one after CDB
    do_issue(1'b0, 32'd0, 4'd8, 32'd1, 4'd0);
    do_issue(1'b0, 32'd3, 4'd0, 32'd4, 4'd0);
    step();
    exp_q.push_back(mk(1'b0, 4'd2, 32'd3, 32'd4));
    chk_offer("t5_slot1");
    cdb_valid = 1'b1; cdb_tag = 4'd8; cdb_data = 32'd50;
    step();
    cdb_valid = 1'b0;
    chk_offer("t5_hold_cdb");
    exp_q.push_back(mk(1'b0, 4'd1, 32'd50, 32'd1));
    ack_offer("t5_ack_slot1");
    ack_offer("t5_slot0_b2b");
    chk("t5_en_off", CW'(alu_en), CW'(1'b0));

    // 6a: flush during offer with two busy slots
    do_issue(1'b0, 32'd0, 4'd5, 32'd2, 4'd0);
    do_issue(1'b0, 32'd7, 4'd0, 32'd8, 4'd0);
    step();
    exp_q.push_back(mk(1'b0, 4'd2, 32'd7, 32'd8));
    chk_offer("t6_pre_flush");
    void'(exp_q.pop_front());
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t6_flush_en", CW'(alu_en), CW'(1'b0));
    chk("t6_flush_ready", CW'(issue_ready), CW'(1'b1));
    chk("t6_flush_tag", CW'(issue_tag), CW'(4'd1));
    cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'd9;
    step();
    cdb_valid = 1'b0;
    step();
    step();
    chk("t6_flush_no_dispatch", CW'(alu_en), CW'(1'b0));

    // 6b: asynchronous reset mid-offer
    do_issue(1'b0, 32'd11, 4'd0, 32'd12, 4'd0);
    step();
    exp_q.push_back(mk(1'b0, 4'd1, 32'd11, 32'd12));
    chk_offer("t6_pre_reset");
    void'(exp_q.pop_front());
    #2;
    nRST = 1'b0;
    #1;
    chk("t6_rst_en", CW'(alu_en), CW'(1'b0));
    chk("t6_rst_word", alu_word, '0);
    chk("t6_rst_ready", CW'(issue_ready), CW'(1'b1));
    @(negedge clk);
    nRST = 1'b1;
    step();
    step();
    chk("t6_rst_no_dispatch", CW'(alu_en), CW'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
